// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: circular FIFO with sticky overrun/framing flags.
// Latency: a byte pushed at edge N is visible on out_data/out_valid in cycle N+1 (no bypass).
// Backpressure: out_ready stalls the head; the UART side cannot stall, so a byte arriving while full is dropped and flagged.
module uart_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    input  logic                    in_frame_err,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    flush,
    input  logic                    clear_errors,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    overrun,
    output logic                    frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Byte storage; contents are deliberately left unreset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          overrun_q;
    logic          frame_err_q;

    logic byte_ok;
    logic byte_bad;
    logic pop;
    logic push;
    logic ovr_set;

    // All status outputs come straight from registers, never from inputs.
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign out_valid = !empty;
    assign count     = count_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

    // Show-ahead head of queue.
    assign out_data  = mem[rd_ptr];

    // A clean byte is stored when there is room, or when a pop in the same cycle makes room.
    assign byte_ok  = in_valid && !in_frame_err;
    assign byte_bad = in_valid && in_frame_err;
    assign pop      = out_valid && out_ready;
    assign push     = byte_ok && (!full || pop);
    // Overrun is not evaluated in a flush cycle: the buffer is being emptied anyway.
    assign ovr_set  = byte_ok && full && !pop && !flush;

    // Pointer and occupancy tracking; flush discards everything including a same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Write the accepted byte at the tail slot.
    always_ff @(posedge clk) begin
        if (rst && push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Sticky error flags; a set in the same cycle as clear_errors wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overrun_q   <= ovr_set  || (overrun_q   && !clear_errors);
            frame_err_q <= byte_bad || (frame_err_q && !clear_errors);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a randomized stream.
// Outputs are sampled 1 time unit after each rising clock edge; inputs change at the same point.
// Reference model is a byte queue plus two sticky bits updated from the buffer's rules.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_frame_err;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          flush;
    logic          clear_errors;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overrun;
    logic          frame_err;

    uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_frame_err (in_frame_err),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .flush        (flush),
        .clear_errors (clear_errors),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference: contents as an ordered queue, plus sticky flags.
    logic [DW-1:0] mq[$];
    logic          m_ovr = 1'b0;
    logic          m_ferr = 1'b0;

    task automatic idle();
        in_valid     = 1'b0;
        in_frame_err = 1'b0;
        in_data      = '0;
        out_ready    = 1'b0;
        flush        = 1'b0;
        clear_errors = 1'b0;
    endtask

    task automatic model_update();
        bit pop_m;
        bit ok;
        bit ovr_hit;
        if (!rst) begin
            mq.delete();
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end else begin
            pop_m = (mq.size() != 0) && out_ready;
            ok    = in_valid && !in_frame_err;
            if (flush) begin
                mq.delete();
                if (clear_errors) m_ovr = 1'b0;
            end else begin
                ovr_hit = ok && (mq.size() == DEPTH) && !pop_m;
                if (pop_m) void'(mq.pop_front());
                if (ok && !ovr_hit) mq.push_back(in_data);
                if (ovr_hit) m_ovr = 1'b1;
                else if (clear_errors) m_ovr = 1'b0;
            end
            if (in_valid && in_frame_err) m_ferr = 1'b1;
            else if (clear_errors) m_ferr = 1'b0;
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [DW-1:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_checks++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 ||
            overrun !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b valid=%b ovr=%b ferr=%b, want 0 1 0 0 0 0",
                     count, empty, full, out_valid, overrun, frame_err);
        end
    endtask

    task automatic test_single();
        push_byte(8'hA5);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || count !== CW'(1) || empty !== 1'b0) begin
            n_fail++;
            $display("FAIL single_push: valid=%b data=%h count=%0d empty=%b, want 1 a5 1 0",
                     out_valid, out_data, count, empty);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (count !== '0 || empty !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: count=%0d empty=%b valid=%b, want 0 1 0", count, empty, out_valid);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < DEPTH; i++) push_byte(8'(i));
        n_checks++;
        if (full !== 1'b1 || count !== CW'(DEPTH) || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: full=%b count=%0d ovr=%b, want 1 16 0", full, count, overrun);
        end
        push_byte(8'h10);
        n_checks++;
        if (overrun !== 1'b1 || count !== CW'(DEPTH) || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL overrun_drop: ovr=%b count=%0d head=%h, want 1 16 00", overrun, count, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                n_fail++;
                $display("FAIL overrun_drain[%0d]: valid=%b data=%h, want 1 %h", i, out_valid, out_data, 8'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (empty !== 1'b1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_after_drain: empty=%b ovr=%b, want 1 1 (0x10 must not be stored)", empty, overrun);
        end
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: ovr=%b, want 0", overrun);
        end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] last;
        last = '0;
        for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i));
        in_valid  = 1'b1;
        in_data   = 8'h55;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        n_checks++;
        if (count !== CW'(DEPTH) || overrun !== 1'b0 || out_data !== 8'h21) begin
            n_fail++;
            $display("FAIL full_push_pop: count=%0d ovr=%b head=%h, want 16 0 21", count, overrun, out_data);
        end
        for (int i = 0; i < DEPTH; i++) begin
            last = out_data;
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (last !== 8'h55 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL full_push_pop_last: last=%h empty=%b, want 55 1", last, empty);
        end
    endtask

    task automatic test_frame_err();
        push_byte(8'h12);
        in_valid     = 1'b1;
        in_frame_err = 1'b1;
        in_data      = 8'h3C;
        tick();
        n_checks++;
        if (frame_err !== 1'b1 || count !== CW'(1) || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err_set: ferr=%b count=%0d ovr=%b, want 1 1 0", frame_err, count, overrun);
        end
        clear_errors = 1'b1;
        in_data      = 8'h4D;
        tick();
        n_checks++;
        if (frame_err !== 1'b1 || count !== CW'(1)) begin
            n_fail++;
            $display("FAIL frame_err_set_wins: ferr=%b count=%0d, want 1 1", frame_err, count);
        end
        in_valid     = 1'b0;
        in_frame_err = 1'b0;
        tick();
        clear_errors = 1'b0;
        n_checks++;
        if (frame_err !== 1'b0 || out_data !== 8'h12) begin
            n_fail++;
            $display("FAIL frame_err_clear: ferr=%b head=%h, want 0 12", frame_err, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) push_byte(8'hA0 + 8'(i));
        n_checks++;
        if (count !== CW'(5)) begin
            n_fail++;
            $display("FAIL flush_prefill: count=%0d, want 5", count);
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (count !== '0 || empty !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_empty: count=%0d empty=%b valid=%b, want 0 1 0", count, empty, out_valid);
        end
        push_byte(8'h88);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h88 || count !== CW'(1)) begin
            n_fail++;
            $display("FAIL flush_next: valid=%b data=%h count=%0d, want 1 88 1", out_valid, out_data, count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random_stream();
        int pushes;
        int cycles;
        pushes = 0;
        cycles = 0;
        while (pushes < 40 && cycles < 1000) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_frame_err = in_valid && ($urandom_range(0, 15) == 0);
            in_data      = 8'($urandom);
            out_ready    = 1'($urandom_range(0, 1));
            n_checks++;
            if (count !== CW'(mq.size()) || out_valid !== (mq.size() != 0) ||
                (mq.size() != 0 && out_data !== mq[0]) || overrun !== m_ovr || frame_err !== m_ferr) begin
                n_fail++;
                $display("FAIL random_stream[%0d]: count=%0d valid=%b data=%h ovr=%b ferr=%b, want %0d %b %h %b %b",
                         cycles, count, out_valid, out_data, overrun, frame_err, mq.size(), mq.size() != 0,
                         (mq.size() != 0) ? mq[0] : 8'h00, m_ovr, m_ferr);
            end
            if (in_valid && !in_frame_err) pushes++;
            tick();
            cycles++;
        end
        n_checks++;
        if (pushes < 40) begin
            n_fail++;
            $display("FAIL random_budget: pushes=%0d, want 40", pushes);
        end
        idle();
        out_ready = 1'b1;
        cycles = 0;
        while (mq.size() != 0 && cycles < 2 * DEPTH) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== mq[0]) begin
                n_fail++;
                $display("FAIL random_drain[%0d]: valid=%b data=%h, want 1 %h", cycles, out_valid, out_data, mq[0]);
            end
            tick();
            cycles++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (empty !== 1'b1 || mq.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain_end: empty=%b model_size=%0d, want 1 0", empty, mq.size());
        end
    endtask

    task automatic test_midstream_reset();
        for (int i = 0; i < 3; i++) push_byte(8'($urandom));
        in_valid     = 1'b1;
        in_frame_err = 1'b1;
        tick();
        in_frame_err = 1'b0;
        in_data      = 8'hE1;
        out_ready    = 1'b1;
        flush        = 1'b1;
        rst          = 1'b0;
        tick();
        rst = 1'b1;
        idle();
        n_checks++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 ||
            overrun !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midstream_reset: count=%0d empty=%b full=%b valid=%b ovr=%b ferr=%b, want 0 1 0 0 0 0",
                     count, empty, full, out_valid, overrun, frame_err);
        end
    endtask

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_single();
        test_overrun();
        test_full_push_pop();
        test_frame_err();
        test_flush();
        test_random_stream();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
